// File: rtl/alu_exec_pipe.sv
// alu_exec_pipe: registered execute-stage ALU. Single-cycle ops pass through one
// operand stage and then into the result/flag registers. MUL runs as an
// iterative shift-add and stalls the sender for its whole duration.
module alu_exec_pipe #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src,
    input  logic [WIDTH-1:0] dst,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int unsigned CntW = $clog2(MUL_CYCLES + 1);

    typedef enum logic [2:0] {
        OpAdd   = 3'b000,
        OpNot   = 3'b001,
        OpLoad  = 3'b010,
        OpStore = 3'b011,
        OpNop   = 3'b100,
        OpSub   = 3'b101,
        OpAnd   = 3'b110,
        OpMul   = 3'b111
    } op_e;

    // Operand stage for single-cycle ops
    logic             pv_q, pv_d;
    op_e              pop_q, pop_d;
    logic [WIDTH-1:0] psrc_q, psrc_d;
    logic [WIDTH-1:0] pdst_q, pdst_d;

    // Multiplier state
    logic               busy_q, busy_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    // Architectural outputs
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             out_valid_q, out_valid_d;

    logic               accept;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   not_r;
    logic [WIDTH-1:0]   and_r;
    logic               add_v;
    logic               sub_v;
    logic [2*WIDTH-1:0] acc_step;

    assign in_ready  = !busy_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

    assign accept   = in_valid && !busy_q;
    assign sum      = {1'b0, psrc_q} + {1'b0, pdst_q};
    // Top bit of the widened difference is the unsigned borrow
    assign diff     = {1'b0, psrc_q} - {1'b0, pdst_q};
    assign not_r    = ~psrc_q;
    assign and_r    = psrc_q & pdst_q;
    assign add_v    = (psrc_q[WIDTH-1] == pdst_q[WIDTH-1]) &&
                      (sum[WIDTH-1] != psrc_q[WIDTH-1]);
    assign sub_v    = (psrc_q[WIDTH-1] != pdst_q[WIDTH-1]) &&
                      (diff[WIDTH-1] != psrc_q[WIDTH-1]);
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Next-state: accept/stage operands, execute staged op, step the multiplier
    always_comb begin
        pv_d        = 1'b0;
        pop_d       = pop_q;
        psrc_d      = psrc_q;
        pdst_d      = pdst_q;
        busy_d      = busy_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = 1'b0;

        if (accept) begin
            if (op_e'(op) == OpMul) begin
                busy_d   = 1'b1;
                cnt_d    = '0;
                mcand_d  = {{WIDTH{1'b0}}, src};
                mplier_d = dst;
                acc_d    = '0;
            end else begin
                // NOP is accepted but never staged, so it produces nothing
                pv_d   = (op_e'(op) != OpNop);
                pop_d  = op_e'(op);
                psrc_d = src;
                pdst_d = dst;
            end
        end

        if (pv_q) begin
            out_valid_d = 1'b1;
            unique case (pop_q)
                OpAdd, OpLoad: begin
                    result_d = sum[WIDTH-1:0];
                    flags_d  = {add_v, sum[WIDTH-1], sum[WIDTH-1:0] == '0, sum[WIDTH]};
                end
                OpSub: begin
                    result_d = diff[WIDTH-1:0];
                    flags_d  = {sub_v, diff[WIDTH-1], diff[WIDTH-1:0] == '0, diff[WIDTH]};
                end
                OpNot: begin
                    result_d = not_r;
                    flags_d  = {1'b0, 1'b0, not_r == '0, 1'b0};
                end
                OpAnd: begin
                    result_d = and_r;
                    flags_d  = {1'b0, and_r[WIDTH-1], and_r == '0, 1'b0};
                end
                OpStore: begin
                    result_d = pdst_q;
                end
                default: begin
                    out_valid_d = 1'b0;
                end
            endcase
        end

        if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CntW'(1);
            if (cnt_q == CntW'(MUL_CYCLES - 1)) begin
                busy_d      = 1'b0;
                out_valid_d = 1'b1;
                result_d    = acc_step[WIDTH-1:0];
                flags_d     = {1'b0, acc_step[WIDTH-1], acc_step[WIDTH-1:0] == '0,
                               acc_step[2*WIDTH-1:WIDTH] != '0};
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pv_q        <= 1'b0;
            pop_q       <= OpNop;
            psrc_q      <= '0;
            pdst_q      <= '0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            pv_q        <= pv_d;
            pop_q       <= pop_d;
            psrc_q      <= psrc_d;
            pdst_q      <= pdst_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Bench for alu_exec_pipe: a 16-bit and an 8-bit instance, each shadowed by an
// arithmetic reference model with a per-cycle compare, plus directed literal checks.
module tb_alu_exec_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv   [2];
    logic [2:0]  opv  [2];
    logic [15:0] srcv [2];
    logic [15:0] dstv [2];

    logic        ov0, ov1, rdy0, rdy1;
    logic [3:0]  fl0, fl1;
    logic [15:0] res0;
    logic [7:0]  res1;

    int checks = 0;
    int errors = 0;

    alu_exec_pipe #(.WIDTH(16), .MUL_CYCLES(16)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv[0]),
        .in_ready  (rdy0),
        .op        (opv[0]),
        .src       (srcv[0]),
        .dst       (dstv[0]),
        .out_valid (ov0),
        .result    (res0),
        .flags     (fl0)
    );

    alu_exec_pipe #(.WIDTH(8), .MUL_CYCLES(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv[1]),
        .in_ready  (rdy1),
        .op        (opv[1]),
        .src       (srcv[1][7:0]),
        .dst       (dstv[1][7:0]),
        .out_valid (ov1),
        .result    (res1),
        .flags     (fl1)
    );

    function automatic logic get_ov(input int d);
        return (d != 0) ? ov1 : ov0;
    endfunction
    function automatic logic get_rdy(input int d);
        return (d != 0) ? rdy1 : rdy0;
    endfunction
    function automatic logic [3:0] get_fl(input int d);
        return (d != 0) ? fl1 : fl0;
    endfunction
    function automatic logic [15:0] get_res(input int d);
        return (d != 0) ? {8'h00, res1} : res0;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s w%0d got=%0h want=%0h", name, (d != 0) ? 8 : 16, got, exp);
        end
    endtask

    // Reference semantics from plain integer arithmetic
    function automatic void ref_op(input logic [2:0] o, input longint ai, input longint bi,
                                   input int w, output logic [15:0] r, output logic [3:0] f,
                                   output bit upd, output bit has);
        longint mask, msb, a, b, s, rr;
        bit c, z, n, v;
        mask = (longint'(1) << w) - 1;
        msb  = longint'(1) << (w - 1);
        a = ai & mask;
        b = bi & mask;
        has = 1; upd = 1; c = 0; v = 0; rr = 0; s = 0;
        case (o)
            3'd0, 3'd2: begin
                s  = a + b;
                rr = s & mask;
                c  = (s > mask);
                v  = ((a & msb) == (b & msb)) && ((rr & msb) != (a & msb));
            end
            3'd5: begin
                rr = (a - b) & mask;
                c  = (a < b);
                v  = ((a & msb) != (b & msb)) && ((rr & msb) != (a & msb));
            end
            3'd1: rr = (~a) & mask;
            3'd6: rr = a & b;
            3'd3: begin rr = b; upd = 0; end
            3'd4: begin has = 0; upd = 0; end
            default: begin
                s  = a * b;
                rr = s & mask;
                c  = ((s >> w) != 0);
            end
        endcase
        z = (rr == 0);
        n = ((rr & msb) != 0) && (o != 3'd1);
        r = 16'(rr);
        f = {v, n, z, c};
    endfunction

    // Model state: at most one completion is ever pending per instance
    int unsigned cyc = 0;
    bit          m_init = 0;
    bit          m_mul  [2];
    int unsigned m_mul_t[2];
    bit          p_v    [2];
    int unsigned p_due  [2];
    logic [15:0] p_res  [2];
    logic [3:0]  p_fl   [2];
    bit          p_upd  [2];
    logic        exp_ov [2];
    logic        exp_rdy[2];
    logic [15:0] exp_res[2];
    logic [3:0]  exp_fl [2];

    // Model advances on each rising edge using the inputs the DUT samples
    always @(posedge clk) begin
        int unsigned w;
        logic [15:0] r;
        logic [3:0]  f;
        bit upd, has, ready;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            w = (d != 0) ? 8 : 16;
            if (rst) begin
                m_mul[d]   = 0;
                p_v[d]     = 0;
                exp_ov[d]  = 0;
                exp_res[d] = '0;
                exp_fl[d]  = '0;
                exp_rdy[d] = 1;
            end else begin
                ready     = !(m_mul[d] && cyc <= m_mul_t[d] + w);
                exp_ov[d] = 0;
                if (p_v[d] && p_due[d] == cyc) begin
                    exp_ov[d]  = 1;
                    exp_res[d] = p_res[d];
                    if (p_upd[d]) exp_fl[d] = p_fl[d];
                    p_v[d] = 0;
                end
                if (iv[d] && ready) begin
                    ref_op(opv[d], longint'(srcv[d]), longint'(dstv[d]), w, r, f, upd, has);
                    if (has) begin
                        p_v[d]   = 1;
                        p_due[d] = cyc + ((opv[d] == 3'd7) ? w : 1);
                        p_res[d] = r;
                        p_fl[d]  = f;
                        p_upd[d] = upd;
                    end
                    if (opv[d] == 3'd7) begin
                        m_mul[d]   = 1;
                        m_mul_t[d] = cyc;
                    end
                end
                exp_rdy[d] = !(m_mul[d] && cyc < m_mul_t[d] + w);
            end
        end
        m_init = 1;
    end

    // Compare every cycle on the falling edge
    always @(negedge clk) begin
        if (m_init) begin
            for (int d = 0; d < 2; d++) begin
                chk("model_out_valid", d, 32'(get_ov(d)), 32'(exp_ov[d]));
                chk("model_in_ready", d, 32'(get_rdy(d)), 32'(exp_rdy[d]));
                chk("model_result", d, 32'(get_res(d)), 32'(exp_res[d]));
                chk("model_flags", d, 32'(get_fl(d)), 32'(exp_fl[d]));
            end
        end
    end

    // Present an op and hold it until accepted; returns just after the accepting edge
    task automatic send(input int d, input logic [2:0] o, input logic [15:0] a,
                        input logic [15:0] b);
        int n;
        opv[d] = o; srcv[d] = a; dstv[d] = b; iv[d] = 1'b1;
        n = 0;
        while (!get_rdy(d) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL send_timeout w%0d got=stalled want=accept", (d != 0) ? 8 : 16);
        end
        @(negedge clk);
    endtask

    task automatic wait_out(input int d, input int lat, input logic [15:0] r,
                            input logic [3:0] f);
        int k;
        iv[d] = 1'b0;
        k = 0;
        while (!get_ov(d) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("lit_latency", d, 32'(k), 32'(lat));
        chk("lit_result", d, 32'(get_res(d)), 32'(r));
        chk("lit_flags", d, 32'(get_fl(d)), 32'(f));
    endtask

    function automatic logic [15:0] pick(input int w);
        logic [15:0] mask, msb;
        mask = 16'((32'd1 << w) - 1);
        msb  = 16'(32'd1 << (w - 1));
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return mask;
            2:       return msb;
            3:       return msb - 16'd1;
            4:       return 16'd1;
            default: return 16'($urandom) & mask;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall;
        int cnt;
        bit seen;
        logic [15:0] cap_res;
        logic [3:0] cap_fl;
        seen = 0; cap_res = '0; cap_fl = '0;

        // Reset held with a live ADD on the inputs
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b1; opv[d] = 3'd0; srcv[d] = 16'h1234; dstv[d] = 16'h0101;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_result", d, 32'(get_res(d)), 32'h0);
            chk("rst_flags", d, 32'(get_fl(d)), 32'h0);
            chk("rst_out_valid", d, 32'(get_ov(d)), 32'h0);
            iv[d] = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 0, 32'(get_rdy(0)), 32'h1);
        chk("rst_in_ready", 1, 32'(get_rdy(1)), 32'h1);

        // ADD overflow and carry
        send(0, 3'd0, 16'h7FFF, 16'h0001);
        wait_out(0, 1, 16'h8000, 4'b1100);
        send(0, 3'd0, 16'hFFFF, 16'h0001);
        wait_out(0, 1, 16'h0000, 4'b0011);

        // Back-to-back SUB/NOT/STORE/NOP
        send(0, 3'd5, 16'h0003, 16'h0005);
        send(0, 3'd1, 16'hFFFF, 16'h0000);
        send(0, 3'd3, 16'h0000, 16'h1234);
        send(0, 3'd4, 16'h5555, 16'h5555);
        iv[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("stream_result", 0, 32'(get_res(0)), 32'h1234);
        chk("stream_flags", 0, 32'(get_fl(0)), 32'b0010);

        // MUL stall with an ADD held on the inputs
        send(0, 3'd7, 16'h0100, 16'h0101);
        opv[0] = 3'd0; srcv[0] = 16'h0001; dstv[0] = 16'h0002; iv[0] = 1'b1;
        stall = 0;
        for (int i = 0; i < 40; i++) begin
            if (!get_rdy(0)) stall++;
            if (get_ov(0)) begin
                seen = 1; cap_res = get_res(0); cap_fl = get_fl(0);
            end
            if (get_rdy(0)) break;
            @(negedge clk);
        end
        chk("mul_stall_cycles", 0, 32'(stall), 32'd16);
        chk("mul_seen", 0, 32'(seen), 32'h1);
        chk("mul_result", 0, 32'(cap_res), 32'h0100);
        chk("mul_flags", 0, 32'(cap_fl), 32'b0001);
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("held_add_result", 0, 32'(get_res(0)), 32'h0003);

        // Reset in the middle of a MUL
        send(0, 3'd7, 16'h1234, 16'h0057);
        iv[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_result", 0, 32'(get_res(0)), 32'h0);
        chk("abort_flags", 0, 32'(get_fl(0)), 32'h0);
        @(negedge clk);
        chk("abort_in_ready", 0, 32'(get_rdy(0)), 32'h1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (get_ov(0)) cnt++;
            @(negedge clk);
        end
        chk("abort_no_out_valid", 0, 32'(cnt), 32'h0);

        // 8-bit instance
        send(1, 3'd0, 16'h00FF, 16'h0001);
        wait_out(1, 1, 16'h0000, 4'b0011);
        send(1, 3'd7, 16'h0010, 16'h0010);
        wait_out(1, 8, 16'h0000, 4'b0011);

        // Randomized traffic, model-checked every cycle
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 250; i++) begin
                send(d, 3'($urandom_range(0, 7)), pick((d != 0) ? 8 : 16),
                     pick((d != 0) ? 8 : 16));
                if ($urandom_range(0, 1) == 1) begin
                    iv[d] = 1'b0;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            iv[d] = 1'b0;
            repeat (20) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
